// File: rtl/sub3_pipe_if.sv
// rtl/sub3_pipe_if.sv - operand/result handshake bundle for sub3_pipe
//
// Purpose: carries the valid/ready operand channel (a, b, c) into sub3_pipe
// and the valid/ready result channel (diff) out of it.
// Ports (signals):
//   in_valid  operands a/b/c valid this cycle (producer -> pipe)
//   in_ready  pipe accepts operands this cycle (pipe -> producer)
//   a, b, c   signed operands, widths A_WIDTH/B_WIDTH/C_WIDTH
//   out_valid diff holds a valid result (pipe -> consumer)
//   out_ready consumer takes diff this cycle (consumer -> pipe)
//   diff      signed a - b - c, OUT_WIDTH bits
// Modports: master = producer/consumer side, slave = pipeline side.
interface sub3_pipe_if #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int C_WIDTH = 8
);
  localparam int D_WIDTH   = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1;
  localparam int OUT_WIDTH = ((D_WIDTH > C_WIDTH) ? D_WIDTH : C_WIDTH) + 1;

  logic                        in_valid;
  logic                        in_ready;
  logic signed [A_WIDTH-1:0]   a;
  logic signed [B_WIDTH-1:0]   b;
  logic signed [C_WIDTH-1:0]   c;
  logic                        out_valid;
  logic                        out_ready;
  logic signed [OUT_WIDTH-1:0] diff;

  modport master (
    output in_valid, a, b, c, out_ready,
    input  in_ready, out_valid, diff
  );

  modport slave (
    input  in_valid, a, b, c, out_ready,
    output in_ready, out_valid, diff
  );
endinterface

// File: rtl/sub3_pipe.sv
// rtl/sub3_pipe.sv - two-stage valid/ready pipelined a - b - c
//
// Purpose: stage 1 registers a - b at D_WIDTH and carries c alongside;
// stage 2 registers (a - b) - c at OUT_WIDTH. Widths grow one bit per
// subtraction, so the result is exact for every operand combination.
// Ports:
//   clk    rising-edge clock
//   rst_b  asynchronous active-low reset; clears both valid flags and data
//   bus    sub3_pipe_if.slave: in_valid/in_ready/a/b/c in,
//          out_valid/out_ready/diff out
module sub3_pipe #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int C_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_b,
  sub3_pipe_if.slave     bus
);
  localparam int D_WIDTH   = ((A_WIDTH > B_WIDTH) ? A_WIDTH : B_WIDTH) + 1;
  localparam int OUT_WIDTH = ((D_WIDTH > C_WIDTH) ? D_WIDTH : C_WIDTH) + 1;

  logic                        s1_valid;
  logic signed [D_WIDTH-1:0]   s1_d;
  logic signed [C_WIDTH-1:0]   s1_c;
  logic                        out_valid_q;
  logic signed [OUT_WIDTH-1:0] diff_q;

  logic                        s2_load;
  logic                        s1_load;
  logic signed [D_WIDTH-1:0]   a_ext;
  logic signed [D_WIDTH-1:0]   b_ext;
  logic signed [OUT_WIDTH-1:0] s1_d_ext;
  logic signed [OUT_WIDTH-1:0] s1_c_ext;

  // Every extension below is at least one bit wide because each derived
  // width is strictly larger than the operands it is built from.
  assign a_ext    = {{(D_WIDTH - A_WIDTH){bus.a[A_WIDTH-1]}}, bus.a};
  assign b_ext    = {{(D_WIDTH - B_WIDTH){bus.b[B_WIDTH-1]}}, bus.b};
  assign s1_d_ext = {{(OUT_WIDTH - D_WIDTH){s1_d[D_WIDTH-1]}}, s1_d};
  assign s1_c_ext = {{(OUT_WIDTH - C_WIDTH){s1_c[C_WIDTH-1]}}, s1_c};

  // Stage 2 takes stage 1 whenever its own slot is empty or being drained.
  assign s2_load = s1_valid && (!out_valid_q || bus.out_ready);
  // Stage 1 accepts when empty or when its content moves on this cycle.
  assign s1_load = bus.in_valid && (!s1_valid || s2_load);

  // Independent of in_valid so producers may wait on in_ready.
  assign bus.in_ready  = !s1_valid || !out_valid_q || bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.diff      = diff_q;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
      s1_c     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_d     <= a_ext - b_ext;
        s1_c     <= bus.c;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
    end else begin
      if (s2_load) begin
        out_valid_q <= 1'b1;
        diff_q      <= s1_d_ext - s1_c_ext;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sub3_pipe.sv
// tb/tb_sub3_pipe.sv - self-checking bench for sub3_pipe
module tb_sub3_pipe;
  localparam int A_WIDTH = 8;
  localparam int B_WIDTH = 8;
  localparam int C_WIDTH = 8;

  logic clk;
  logic rst_b;
  int   checks;
  int   errors;
  int   model_q[$];

  sub3_pipe_if #(.A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .C_WIDTH(C_WIDTH)) bus ();

  sub3_pipe #(.A_WIDTH(A_WIDTH), .B_WIDTH(B_WIDTH), .C_WIDTH(C_WIDTH)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic int rnd();
    return int'($urandom_range(255)) - 128;
  endfunction

  task automatic drive(input bit v, input int av, input int bv, input int cv);
    bus.in_valid = v;
    bus.a = av[A_WIDTH-1:0];
    bus.b = bv[B_WIDTH-1:0];
    bus.c = cv[C_WIDTH-1:0];
  endtask

  // One clock: note the transfers that will happen at the coming edge,
  // record accepted operands in the model as a - b - c, then step the clock.
  task automatic tick(output bit ifire, output bit ofire, output int odiff);
    #1;
    ifire = bus.in_valid && bus.in_ready;
    ofire = bus.out_valid && bus.out_ready;
    odiff = int'(bus.diff);
    if (ifire) model_q.push_back(int'(bus.a) - int'(bus.b) - int'(bus.c));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++; if (int'(bus.diff) !== 0) begin errors++; $display("FAIL reset_diff got %0d want 0", int'(bus.diff)); end
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", bus.in_ready); end
    @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_single();
    bit i, o;
    int d, exp;
    bus.out_ready = 1'b1;
    drive(1, 5, -3, 10);
    tick(i, o, d);
    checks++; if (i !== 1'b1) begin errors++; $display("FAIL single_accept got %b want 1", i); end
    drive(0, 0, 0, 0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_lat1 out_valid got %b want 0", bus.out_valid); end
    tick(i, o, d);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL single_lat2 out_valid got %b want 1", bus.out_valid); end
    checks++; if (int'(bus.diff) !== -2) begin errors++; $display("FAIL single_diff got %0d want -2", int'(bus.diff)); end
    tick(i, o, d);
    checks++;
    if (!o || model_q.size() == 0) begin errors++; $display("FAIL single_take ofire %b queued %0d", o, model_q.size()); end
    else begin exp = model_q.pop_front(); if (d !== exp) begin errors++; $display("FAIL single_model got %0d want %0d", d, exp); end end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL single_clear out_valid got %b want 0", bus.out_valid); end
  endtask

  task automatic test_extremes();
    bit i, o;
    int d, exp, n;
    int got[2];
    n = 0;
    bus.out_ready = 1'b1;
    drive(1, -128, 127, 127);
    tick(i, o, d);
    drive(1, 127, -128, -128);
    tick(i, o, d);
    drive(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      tick(i, o, d);
      if (o) begin
        if (n < 2) got[n] = d;
        n++;
        checks++;
        if (model_q.size() == 0) begin errors++; $display("FAIL ext_unexpected diff %0d", d); end
        else begin exp = model_q.pop_front(); if (d !== exp) begin errors++; $display("FAIL ext_model got %0d want %0d", d, exp); end end
      end
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL ext_count got %0d want 2", n); end
    else begin
      checks++; if (got[0] !== -382) begin errors++; $display("FAIL ext_min got %0d want -382", got[0]); end
      checks++; if (got[1] !== 383) begin errors++; $display("FAIL ext_max got %0d want 383", got[1]); end
    end
  endtask

  task automatic test_streaming();
    bit i, o;
    int d, exp, n, first, last;
    n = 0; first = -1; last = -1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k < 16) begin
        drive(1, rnd(), rnd(), rnd());
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cycle %0d got %b want 1", k, bus.in_ready); end
      end else begin
        drive(0, 0, 0, 0);
      end
      tick(i, o, d);
      if (o) begin
        if (first < 0) first = k;
        last = k;
        n++;
        checks++;
        if (model_q.size() == 0) begin errors++; $display("FAIL stream_unexpected diff %0d", d); end
        else begin exp = model_q.pop_front(); if (d !== exp) begin errors++; $display("FAIL stream_model got %0d want %0d", d, exp); end end
      end
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL stream_count got %0d want 16", n); end
    checks++; if (first !== 2) begin errors++; $display("FAIL stream_first got %0d want 2", first); end
    checks++; if (last - first !== 15) begin errors++; $display("FAIL stream_gapless span got %0d want 15", last - first); end
  endtask

  task automatic test_backpressure();
    bit i, o;
    int d, exp, n, acc, held;
    int ta[3], tb[3], tc[3];
    for (int k = 0; k < 3; k++) begin ta[k] = rnd(); tb[k] = rnd(); tc[k] = rnd(); end
    acc = 0; n = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1, ta[acc], tb[acc], tc[acc]);
      tick(i, o, d);
      if (i) acc++;
    end
    checks++; if (acc !== 2) begin errors++; $display("FAIL bp_accepted got %0d want 2", acc); end
    #1;
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid got %b want 1", bus.out_valid); end
    held = int'(bus.diff);
    for (int k = 0; k < 3; k++) begin
      tick(i, o, d);
      if (i) acc++;
      checks++; if (int'(bus.diff) !== held || bus.out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold diff %0d want %0d out_valid %b", int'(bus.diff), held, bus.out_valid);
      end
    end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (acc < 3) drive(1, ta[acc], tb[acc], tc[acc]); else drive(0, 0, 0, 0);
      tick(i, o, d);
      if (i) acc++;
      if (o) begin
        n++;
        checks++;
        if (model_q.size() == 0) begin errors++; $display("FAIL bp_unexpected diff %0d", d); end
        else begin exp = model_q.pop_front(); if (d !== exp) begin errors++; $display("FAIL bp_order got %0d want %0d", d, exp); end end
      end
    end
    checks++; if (acc !== 3 || n !== 3) begin errors++; $display("FAIL bp_drain accepted %0d results %0d want 3 and 3", acc, n); end
  endtask

  task automatic test_swap();
    bit i, o;
    int d, exp, n, acc;
    acc = 0; n = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (acc < 2) drive(1, rnd(), rnd(), rnd()); else drive(0, 0, 0, 0);
      tick(i, o, d);
      if (i) acc++;
    end
    checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL swap_full out_valid %b in_ready %b want 1 0", bus.out_valid, bus.in_ready);
    end
    drive(1, rnd(), rnd(), rnd());
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL swap_in_ready got %b want 1", bus.in_ready); end
    tick(i, o, d);
    checks++; if (i !== 1'b1 || o !== 1'b1) begin errors++; $display("FAIL swap_both_fire in %b out %b want 1 1", i, o); end
    if (o) begin
      checks++;
      if (model_q.size() == 0) begin errors++; $display("FAIL swap_unexpected diff %0d", d); end
      else begin exp = model_q.pop_front(); if (d !== exp) begin errors++; $display("FAIL swap_model got %0d want %0d", d, exp); end end
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL swap_no_bubble out_valid %b want 1", bus.out_valid); end
    drive(0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      tick(i, o, d);
      if (o) begin
        n++;
        checks++;
        if (model_q.size() == 0) begin errors++; $display("FAIL swap_unexpected diff %0d", d); end
        else begin exp = model_q.pop_front(); if (d !== exp) begin errors++; $display("FAIL swap_order got %0d want %0d", d, exp); end end
      end
    end
    checks++; if (n !== 2) begin errors++; $display("FAIL swap_drain got %0d want 2", n); end
  endtask

  task automatic test_reset_mid();
    bit i, o;
    int d, exp, acc;
    acc = 0;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (acc < 2) drive(1, rnd(), rnd(), rnd()); else drive(0, 0, 0, 0);
      tick(i, o, d);
      if (i) acc++;
    end
    rst_b = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got %b want 1", bus.in_ready); end
    model_q.delete();
    drive(0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_b = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick(i, o, d);
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale cycle %0d out_valid %b want 0", k, bus.out_valid); end
    end
    drive(1, rnd(), rnd(), rnd());
    tick(i, o, d);
    drive(0, 0, 0, 0);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_lat1 out_valid %b want 0", bus.out_valid); end
    tick(i, o, d);
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_lat2 out_valid %b want 1", bus.out_valid); end
    tick(i, o, d);
    checks++;
    if (!o || model_q.size() == 0) begin errors++; $display("FAIL rstmid_result ofire %b queued %0d", o, model_q.size()); end
    else begin exp = model_q.pop_front(); if (d !== exp) begin errors++; $display("FAIL rstmid_model got %0d want %0d", d, exp); end end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_b = 1'b0;
    bus.out_ready = 1'b0;
    drive(0, 0, 0, 0);
    test_reset();
    test_single();
    test_extremes();
    test_streaming();
    test_backpressure();
    test_swap();
    test_reset_mid();
    checks++; if (model_q.size() !== 0) begin errors++; $display("FAIL leftover_results got %0d want 0", model_q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sub3_pipe.md
SUB3_PIPE -- requirements
Module: sub3_pipe

Interface
REQ-001 Parameter A_WIDTH, default 8, width of signed operand a.
REQ-002 Parameter B_WIDTH, default 8, width of signed operand b.
REQ-003 Parameter C_WIDTH, default 8, width of signed operand c.
REQ-004 Derived constant D_WIDTH = max(A_WIDTH,B_WIDTH)+1 (stage-1 difference width); OUT_WIDTH = max(D_WIDTH,C_WIDTH)+1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_b  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  a/b/c valid this cycle.
REQ-008 in_ready  output  1  block accepts operands this cycle.
REQ-009 a  input  A_WIDTH  signed minuend.
REQ-010 b  input  B_WIDTH  signed first subtrahend.
REQ-011 c  input  C_WIDTH  signed second subtrahend.
REQ-012 out_valid  output  1  diff holds a valid result.
REQ-013 out_ready  input  1  consumer accepts diff this cycle.
REQ-014 diff  output  OUT_WIDTH  signed result a - b - c.

Function
REQ-015 The block SHALL be a two-stage valid/ready pipeline: stage 1 registers s1_d = a - b (D_WIDTH, sign-extended operands), stage 2 registers diff = s1_d - c (c carried through stage 1 in a register).
REQ-016 Transfer on input SHALL occur when in_valid && in_ready; transfer on output when out_valid && out_ready.
REQ-017 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no backpressure; throughput one result per cycle.
REQ-018 Stage 2 SHALL load from stage 1 when s1_valid && (!out_valid || out_ready); out_valid clears when its result is taken and nothing loads.
REQ-019 Stage 1 SHALL load when in_valid && (!s1_valid || stage-2 load); s1_valid clears when stage 2 loads and no new input arrives.
REQ-020 in_ready SHALL equal !s1_valid || (!out_valid || out_ready), combinationally, with no dependency on in_valid.
REQ-021 Simultaneous input transfer and output transfer with both stages full SHALL shift the pipeline with no bubble and no loss.
REQ-022 While out_valid && !out_ready, diff and out_valid SHALL hold stable; stage 1 SHALL hold once full.
REQ-023 Arithmetic SHALL be exact two's-complement: widths chosen so no overflow for any operand values; no saturation or wrap.
REQ-024 Data registers SHALL update only on their stage load; non-loaded cycles retain value.
REQ-025 At most 2 results SHALL be in flight; no results SHALL be dropped, duplicated or reordered.

Reset
REQ-026 rst_b low SHALL asynchronously clear s1_valid and out_valid to 0; diff and s1 data registers reset to 0.
REQ-027 in_ready SHALL read 1 while in reset and in the first cycle after release.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight results; no out_valid after release until a new input transfer plus 2 cycles.

Verification
REQ-029 Single op: a=5, b=-3, c=10, out_ready=1 -> 2 cycles later out_valid=1, diff=-2, then out_valid=0.
REQ-030 Extremes: a=-128, b=127, c=127 -> diff=-382; a=127, b=-128, c=-128 -> diff=383; no wrap.
REQ-031 Streaming: 16 back-to-back random triples, out_ready=1 -> 16 consecutive results, in order, matching reference model, in_ready constantly 1.
REQ-032 Backpressure: hold out_ready=0 after 3 inputs offered -> exactly 2 accepted, in_ready=0, diff stable; raise out_ready -> results drain in order, third accepted.
REQ-033 Full-pipe swap: both stages full, in_valid=1, out_ready=1 same cycle -> one in, one out, out_valid stays 1.
REQ-034 Reset mid-stream: rst_b low with 2 results in flight -> out_valid=0 immediately, in_ready=1; after release no stale output.
